// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter with next-PC selection and a circular return-address stack.
// Next-PC priority: branch redirect, stall, return, call, sequential.
module pc_fetch_ctrl #(
  parameter int              PC_W      = 7,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_inc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call,
  input  logic [PC_W-1:0] call_target,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_wptr;
  logic [PTR_W-1:0] ras_rptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_full;

  logic [PC_W-1:0]  pc_nxt;
  logic             push;
  logic             pop;
  logic             underflow_set;

  // Top of stack sits one below the write pointer; wrap keeps the stack circular.
  assign ras_rptr  = ras_wptr - PTR_W'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == RAS_FULL);

  always_comb begin
    pc_nxt        = pc;
    push          = 1'b0;
    pop           = 1'b0;
    underflow_set = 1'b0;
    if (pc_valid) begin
      if (branch_taken) begin
        pc_nxt = branch_target;
      end else if (stall) begin
        pc_nxt = pc;
      end else if (ret) begin
        if (ras_empty) begin
          pc_nxt        = pc_inc;
          underflow_set = 1'b1;
        end else begin
          pc_nxt = ras_mem[ras_rptr];
          pop    = 1'b1;
        end
      end else if (call) begin
        pc_nxt = call_target;
        push   = 1'b1;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      ras_cnt       <= '0;
      ras_wptr      <= '0;
      ras_underflow <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      pc       <= pc_nxt;
      if (push) begin
        ras_wptr <= ras_wptr + PTR_W'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (pop) begin
        ras_wptr <= ras_rptr;
        ras_cnt  <= ras_cnt - CNT_W'(1);
      end
      if (underflow_set) ras_underflow <= 1'b1;
    end
  end

  // Entries need no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_wptr] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; the bench itself plays the pc+1 incrementer.
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pc_inc;
  logic       stall;
  logic       branch_taken;
  logic [6:0] branch_target;
  logic       call;
  logic [6:0] call_target;
  logic       ret;
  logic [6:0] pc;
  logic       pc_valid;
  logic       ras_empty;
  logic       ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_ctrl #(.PC_W(7), .RESET_PC(7'd0), .RAS_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_inc        (pc_inc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .call_target   (call_target),
    .ret           (ret),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .ras_empty     (ras_empty),
    .ras_underflow (ras_underflow)
  );

  assign pc_inc = pc + 7'd1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, let the edge happen, sample 1ns later, then clear controls.
  task automatic cyc(input logic br, input logic [6:0] bt, input logic st,
                     input logic c, input logic [6:0] ct, input logic r);
    branch_taken  = br;
    branch_target = bt;
    stall         = st;
    call          = c;
    call_target   = ct;
    ret           = r;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    stall        = 1'b0;
    call         = 1'b0;
    ret          = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic jump(input logic [6:0] t);
    cyc(1'b1, t, 1'b0, 1'b0, 7'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    call = 1'b0; call_target = '0; ret = 1'b0;
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_uflow", 32'(ras_underflow), 32'h0);
    rst_n = 1'b1;

    // 1: first edge only validates; PC then counts up
    idle();
    chk("t1_valid", 32'(pc_valid), 32'h1);
    chk("t1_pc0", 32'(pc), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("t1_seq", 32'(pc), 32'(i));
    end
    chk("t1_empty", 32'(ras_empty), 32'h1);

    // 2: stall holds (call ignored under stall); branch overrides stall
    jump(7'd10);
    chk("t2_at10", 32'(pc), 32'd10);
    cyc(1'b0, 7'd0, 1'b1, 1'b1, 7'h55, 1'b0);
    chk("t2_stall1", 32'(pc), 32'd10);
    chk("t2_stall_call", 32'(ras_empty), 32'h1);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    chk("t2_stall2", 32'(pc), 32'd10);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    chk("t2_stall3", 32'(pc), 32'd10);
    cyc(1'b1, 7'h40, 1'b1, 1'b0, 7'd0, 1'b0);
    chk("t2_br", 32'(pc), 32'h40);

    // 3: simple call/return
    jump(7'd5);
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'h30, 1'b0);
    chk("t3_call", 32'(pc), 32'h30);
    chk("t3_notempty", 32'(ras_empty), 32'h0);
    idle();
    chk("t3_seq1", 32'(pc), 32'h31);
    idle();
    chk("t3_seq2", 32'(pc), 32'h32);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t3_ret", 32'(pc), 32'h06);
    chk("t3_empty", 32'(ras_empty), 32'h1);

    // 4: five nested calls overflow a 4-deep stack, oldest entry lost
    jump(7'd1);
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'h10, 1'b0);
    chk("t4_c1", 32'(pc), 32'h10);
    for (int k = 2; k <= 5; k++) begin
      idle();
      cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'(k * 16), 1'b0);
      chk("t4_call", 32'(pc), 32'(k * 16));
    end
    chk("t4_notempty", 32'(ras_empty), 32'h0);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t4_r1", 32'(pc), 32'h42);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t4_r2", 32'(pc), 32'h32);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t4_r3", 32'(pc), 32'h22);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t4_r4", 32'(pc), 32'h12);
    chk("t4_empty", 32'(ras_empty), 32'h1);
    chk("t4_no_uflow", 32'(ras_underflow), 32'h0);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1);
    chk("t4_r5", 32'(pc), 32'h13);
    chk("t4_uflow", 32'(ras_underflow), 32'h1);
    chk("t4_empty2", 32'(ras_empty), 32'h1);
    idle();
    chk("t4_seq", 32'(pc), 32'h14);
    chk("t4_sticky", 32'(ras_underflow), 32'h1);

    // 5: wrap-around, then branch squashes a same-cycle call
    jump(7'd127);
    chk("t5_at127", 32'(pc), 32'd127);
    idle();
    chk("t5_wrap", 32'(pc), 32'h0);
    cyc(1'b1, 7'h22, 1'b0, 1'b1, 7'h77, 1'b0);
    chk("t5_brcall", 32'(pc), 32'h22);
    chk("t5_nopush", 32'(ras_empty), 32'h1);

    // 6: ret beats call; then asynchronous reset mid-cycle
    jump(7'd6);
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'h50, 1'b0);
    chk("t6_call", 32'(pc), 32'h50);
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 7'h60, 1'b1);
    chk("t6_retcall", 32'(pc), 32'h07);
    chk("t6_popped", 32'(ras_empty), 32'h1);
    idle();
    chk("t6_seq", 32'(pc), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_pc", 32'(pc), 32'h0);
    chk("t6_arst_valid", 32'(pc_valid), 32'h0);
    chk("t6_arst_empty", 32'(ras_empty), 32'h1);
    chk("t6_arst_uflow", 32'(ras_underflow), 32'h0);
    idle();
    chk("t6_hold_rst", 32'(pc_valid), 32'h0);
    rst_n = 1'b1;
    idle();
    chk("t6_rel_valid", 32'(pc_valid), 32'h1);
    chk("t6_rel_pc", 32'(pc), 32'h0);
    idle();
    chk("t6_rel_seq", 32'(pc), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and next-PC selector for the fetch stage. It drives the current PC to instruction memory and to the `sumador` incrementer, and takes the incremented value `pc_inc` back from it. It then picks the next PC from four sources: sequential, branch redirect, call target, or return address. A small circular return-address stack (RAS) handles call/return.

Parameters:
- PC_W, 7, PC width in bits. Matches the incrementer width.
- RESET_PC, 7'd0, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_inc  input  PC_W  pc+1 from the incrementer; combinational function of pc.
- stall  input  1  hazard stall; hold PC and RAS.
- branch_taken  input  1  redirect from the execute stage; flushes the current fetch.
- branch_target  input  PC_W  redirect destination.
- call  input  1  fetched instruction is a call.
- call_target  input  PC_W  call destination.
- ret  input  1  fetched instruction is a return.
- pc  output  PC_W  current fetch address (registered).
- pc_valid  output  1  pc is a legitimate fetch address (registered).
- ras_empty  output  1  RAS holds no entries (registered state, combinational decode).
- ras_underflow  output  1  sticky error flag: a ret was taken with the RAS empty.

Behaviour:

Reset (async assert on rst_n low):
- pc = RESET_PC, pc_valid = 0.
- RAS count = 0, so ras_empty = 1.
- RAS write pointer = 0, ras_underflow = 0.
- RAS storage contents are don't-care.

pc_valid:
- Goes to 1 on the first rising clk edge after rst_n deasserts.
- Stays 1 until the next reset.
- No PC update occurs on that first edge: pc remains RESET_PC.

Next-PC selection, evaluated each edge while pc_valid = 1, highest priority first:
1. branch_taken: pc = branch_target. Overrides stall. Any call or ret in the same cycle is ignored, since that instruction is being flushed. RAS is unchanged.
2. stall: pc and RAS hold. call and ret are ignored.
3. ret: pc = RAS top entry; pop (count-1, pointer-1).
   - If the RAS is empty: pc = pc_inc, ras_underflow is set to 1 and stays 1 until reset, and count stays 0.
   - If call is also asserted, ret wins and the call is ignored.
4. call: pc = call_target; push pc_inc (the return address).
   - If the RAS is full (count = RAS_DEPTH): push overwrites the oldest entry (circular pointer) and count stays RAS_DEPTH.
5. Otherwise: pc = pc_inc.

Arithmetic and timing:
- Wrap-around: when pc = 2^PC_W−1, pc_inc = 0. The block accepts that value unmodified, so the PC wraps to 0.
- Latency: a selection made in cycle N appears on pc after that cycle's edge. Redirect-to-new-pc is 1 cycle; there is no bubble insertion inside this block.
- pc_inc is not registered internally. It must be a pure function of the current pc.

Reset mid-operation:
- Takes effect immediately, regardless of stall, call or ret.
- Pending RAS contents are discarded (count = 0).

Test Plan:
1. Reset release, no controls asserted for 5 cycles → pc sequence 0,0,1,2,3; pc_valid rises at the first edge; ras_empty = 1.
2. From pc = 10: stall for 3 cycles, then branch_taken with target 0x40 while stall is still high → pc holds at 10 for 3 cycles, then 0x40 next cycle.
3. From pc = 5: call to 0x30; run 2 cycles; ret → pc sequence 0x30, 0x31, 0x32, 6; ras_empty returns to 1.
4. Five nested calls issued from pc = 1, 0x11, 0x21, 0x31, 0x41 (targets 0x10, 0x20, 0x30, 0x40, 0x50); then five rets → first four rets return 0x42, 0x32, 0x22, 0x12 (the entry 2 was overwritten); fifth ret → pc_inc, ras_underflow = 1 and stays 1.
5. pc = 127, no controls → next pc = 0; call asserted with branch_taken (target 0x22) → pc = 0x22 and RAS count unchanged.
6. call and ret asserted together with the RAS holding 0x07 → pc = 0x07, RAS popped, no push; assert rst_n low mid-cycle → pc = 0 immediately, pc_valid = 0.
